// File: rtl/mem_pkg.sv
// Shared types and constants for the BIST memory access protocol.
// The BIST tester's FSM typedefs are intended to join this package.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        ACK
    } state_t;

    localparam int DEF_DATA_WIDTH = 4;
    localparam int DEF_AD_WIDTH   = 4;
    localparam int MAX_READ_LAT   = 8;
    // Wide enough to hold READ_LAT-1 for the largest legal latency.
    localparam int CNT_W          = $clog2(MAX_READ_LAT);

endpackage

// File: rtl/mem_array.sv
// Storage array with synchronous write and registered, resettable read port.
// Optional stuck-at-0 on bit 0 of FAULT_ADDR when MEM_FAULT_INJ_EN is defined.
module mem_array
    import mem_pkg::*;
#(
    parameter int data_width = DEF_DATA_WIDTH,
    parameter int ad_width   = DEF_AD_WIDTH,
    parameter int FAULT_ADDR = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [ad_width-1:0]   i_addr,
    input  logic [data_width-1:0] i_wdata,
    output logic [data_width-1:0] o_rdata
);

    localparam int DEPTH = 2 ** ad_width;

    if (FAULT_ADDR < 0 || FAULT_ADDR >= DEPTH) begin : g_fault_addr_check
        $error("mem_array: FAULT_ADDR out of address range");
    end

    logic [data_width-1:0] r_mem [DEPTH];
    logic [data_width-1:0] r_rdata;
    logic [data_width-1:0] w_wdata;
    logic [data_width-1:0] w_rdata;

`ifdef MEM_FAULT_INJ_EN
    localparam logic [ad_width-1:0]   FAULT_IDX = ad_width'(FAULT_ADDR);
    localparam logic [data_width-1:0] BIT0_CLR  = ~data_width'(1);

    // Masked on both sides so even an unwritten faulty word reads bit0=0.
    assign w_wdata = (i_addr == FAULT_IDX) ? (i_wdata & BIT0_CLR) : i_wdata;
    assign w_rdata = (i_addr == FAULT_IDX) ? (r_mem[i_addr] & BIT0_CLR) : r_mem[i_addr];
`else
    assign w_wdata = i_wdata;
    assign w_rdata = r_mem[i_addr];
`endif

    // NOTE: storage has no reset; only the read register is cleared, so
    // the array maps onto plain RAM and contents are undefined until written.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= w_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= w_rdata;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Target side of the BIST req/ack access protocol: one access at a time,
// parameterised read latency. Optional fault injection via MEM_FAULT_INJ_EN.
module mem_responder
    import mem_pkg::*;
#(
    parameter int data_width = DEF_DATA_WIDTH,
    parameter int ad_width   = DEF_AD_WIDTH,
    parameter int READ_LAT   = 1,
    parameter int FAULT_ADDR = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  wr,
    input  logic [ad_width-1:0]   addr,
    input  logic [data_width-1:0] wdata,
    output logic                  ack,
    output logic [data_width-1:0] rdata,
    output logic                  busy,
    output logic                  err
);

    if (READ_LAT < 1 || READ_LAT > MAX_READ_LAT) begin : g_read_lat_check
        $error("mem_responder: READ_LAT must be in 1..8");
    end

    state_t                r_state;
    state_t                w_next_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_next_cnt;
    logic                  r_wr;
    logic [ad_width-1:0]   r_addr;
    logic [data_width-1:0] r_wdata;
    logic                  r_ack;
    logic                  r_busy;
    logic                  r_err;
    logic                  w_err;
    logic                  w_mem_we;
    logic                  w_mem_re;

    // NOTE: every combinational output gets a default before the case so
    // no path leaves a value held, which would infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_err        = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_re     = 1'b0;

        case (r_state)
            IDLE: begin
                if (req) begin
                    w_next_state = ACCESS;
                end
            end
            ACCESS: begin
                // A write commits on this edge even if the request is withdrawn.
                w_mem_we = r_wr;
                if (!req) begin
                    w_next_state = IDLE;
                    w_err        = 1'b1;
                end else if (r_wr) begin
                    w_next_state = ACK;
                end else if (READ_LAT == 1) begin
                    w_mem_re     = 1'b1;
                    w_next_state = ACK;
                end else begin
                    w_next_cnt   = CNT_W'(READ_LAT - 1);
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                w_next_cnt = r_cnt - CNT_W'(1);
                if (!req) begin
                    w_next_state = IDLE;
                    w_err        = 1'b1;
                end else if (r_cnt == CNT_W'(1)) begin
                    w_mem_re     = 1'b1;
                    w_next_state = ACK;
                end
            end
            ACK: begin
                if (!req) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_ack   <= (w_next_state == ACK);
            r_busy  <= (w_next_state != IDLE);
            r_err   <= w_err;
        end
    end

    // Request fields are captured once and held for the whole access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (r_state == IDLE && req) begin
            r_wr    <= wr;
            r_addr  <= addr;
            r_wdata <= wdata;
        end
    end

    mem_array #(
        .data_width (data_width),
        .ad_width   (ad_width),
        .FAULT_ADDR (FAULT_ADDR)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_mem_we),
        .i_re    (w_mem_re),
        .i_addr  (r_addr),
        .i_wdata (r_wdata),
        .o_rdata (rdata)
    );

    assign ack  = r_ack;
    assign busy = r_busy;
    assign err  = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Randomised self-checking bench: two responders (READ_LAT 1 and 4) checked
// against an array-based reference model of the access protocol.
module tb_mem_responder;

    localparam int LAT0       = 1;
    localparam int LAT1       = 4;
    localparam int FAULT_AT   = 7;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [1:0] wr;
    logic [3:0] addr  [2];
    logic [3:0] wdata [2];
    logic [1:0] ack;
    logic [3:0] rdata [2];
    logic [1:0] busy;
    logic [1:0] err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] m_mem      [2][16];
    bit         m_val      [2][16];
    logic [3:0] m_rdata    [2];
    bit         m_rd_known [2];

    mem_responder #(
        .data_width (4), .ad_width (4), .READ_LAT (LAT0), .FAULT_ADDR (FAULT_AT)
    ) dut_l1 (
        .clk (clk), .rst (rst), .req (req[0]), .wr (wr[0]), .addr (addr[0]),
        .wdata (wdata[0]), .ack (ack[0]), .rdata (rdata[0]), .busy (busy[0]), .err (err[0])
    );

    mem_responder #(
        .data_width (4), .ad_width (4), .READ_LAT (LAT1), .FAULT_ADDR (FAULT_AT)
    ) dut_l4 (
        .clk (clk), .rst (rst), .req (req[1]), .wr (wr[1]), .addr (addr[1]),
        .wdata (wdata[1]), .ack (ack[1]), .rdata (rdata[1]), .busy (busy[1]), .err (err[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] stored_value(input logic [3:0] a, input logic [3:0] d);
`ifdef MEM_FAULT_INJ_EN
        if (a == 4'(FAULT_AT)) return d & 4'hE;
`endif
        return d;
    endfunction

    task automatic check_rdata(input int k, input string tag);
        if (m_rd_known[k]) check(tag, 32'(rdata[k]), 32'(m_rdata[k]));
    endtask

    // One complete access on DUT k. abort_edge=0 runs to ack; otherwise req
    // is low when edge E<abort_edge> is sampled.
    task automatic do_access(input int k, input bit is_wr, input logic [3:0] a,
                             input logic [3:0] d, input int abort_edge);
        int lat;
        lat = is_wr ? 1 : ((k == 0) ? LAT0 : LAT1);
        @(negedge clk);
        req[k] = 1'b1; wr[k] = is_wr; addr[k] = a; wdata[k] = d;
        @(posedge clk); #1;
        check("busy_after_e0", 32'(busy[k]), 32'd1);
        check("ack_after_e0", 32'(ack[k]), 32'd0);
        // Request fields must be ignored once latched.
        wr[k] = 1'($urandom); addr[k] = 4'($urandom); wdata[k] = 4'($urandom);

        if (abort_edge > 0) begin
            for (int j = 1; j <= abort_edge; j++) begin
                if (j == abort_edge) req[k] = 1'b0;
                @(posedge clk); #1;
                if (j < abort_edge) begin
                    check("abort_busy_pre", 32'(busy[k]), 32'd1);
                    check("abort_ack_pre", 32'(ack[k]), 32'd0);
                end
            end
            if (is_wr) begin
                m_mem[k][a] = stored_value(a, d);
                m_val[k][a] = 1'b1;
            end
            check("abort_err", 32'(err[k]), 32'd1);
            check("abort_ack", 32'(ack[k]), 32'd0);
            check("abort_busy", 32'(busy[k]), 32'd0);
            check_rdata(k, "abort_rdata_kept");
            @(posedge clk); #1;
            check("abort_err_one_cycle", 32'(err[k]), 32'd0);
            check("abort_no_late_ack", 32'(ack[k]), 32'd0);
            return;
        end

        for (int j = 1; j <= lat; j++) begin
            @(posedge clk); #1;
            check(j < lat ? "ack_early" : "ack_on_time", 32'(ack[k]), (j < lat) ? 32'd0 : 32'd1);
            check("busy_during", 32'(busy[k]), 32'd1);
        end
        check("err_on_ok", 32'(err[k]), 32'd0);
        if (is_wr) begin
            m_mem[k][a] = stored_value(a, d);
            m_val[k][a] = 1'b1;
        end else begin
            m_rd_known[k] = m_val[k][a];
            m_rdata[k]    = m_mem[k][a];
        end
        check_rdata(k, is_wr ? "rdata_after_write" : "read_data");

        repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
            check("ack_hold", 32'(ack[k]), 32'd1);
            check_rdata(k, "rdata_hold");
        end
        req[k] = 1'b0;
        @(posedge clk); #1;
        check("ack_drop", 32'(ack[k]), 32'd0);
        check("busy_drop", 32'(busy[k]), 32'd0);
        check_rdata(k, "rdata_after_drop");
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 16; a++) begin
                m_val[k][a] = 1'b0;
                m_mem[k][a] = '0;
            end
            m_rdata[k]    = '0;
            m_rd_known[k] = 1'b1;
            addr[k]       = '0;
            wdata[k]      = '0;
        end
        req = '0;
        wr  = '0;
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check("reset_ack", 32'(ack[k]), 32'd0);
            check("reset_busy", 32'(busy[k]), 32'd0);
            check("reset_err", 32'(err[k]), 32'd0);
            check("reset_rdata", 32'(rdata[k]), 32'd0);
        end
        @(negedge clk) rst = 1'b1;

        // Asynchronous reset while the READ_LAT=4 responder sits in WAIT.
        @(negedge clk);
        req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 4'h2;
        repeat (3) @(posedge clk);
        #1;
        check("midwait_busy", 32'(busy[1]), 32'd1);
        check("midwait_ack", 32'(ack[1]), 32'd0);
        #2 rst = 1'b0;
        #1;
        check("async_rst_ack", 32'(ack[1]), 32'd0);
        check("async_rst_busy", 32'(busy[1]), 32'd0);
        check("async_rst_err", 32'(err[1]), 32'd0);
        check("async_rst_rdata", 32'(rdata[1]), 32'd0);
        req[1] = 1'b0;
        @(negedge clk) rst = 1'b1;

        // Directed write/read of addr 3 on both latencies.
        for (int k = 0; k < 2; k++) begin
            do_access(k, 1'b1, 4'h3, 4'hA, 0);
            do_access(k, 1'b0, 4'h3, 4'h0, 0);
            check("wr_rd_3_value", 32'(rdata[k]), 32'hA);
        end

        // Write aborted in ACCESS still commits.
        for (int k = 0; k < 2; k++) begin
            do_access(k, 1'b1, 4'h5, 4'h6, 1);
            do_access(k, 1'b0, 4'h5, 4'h0, 0);
            check("aborted_write_kept", 32'(rdata[k]), 32'h6);
        end

        // Read aborts: in ACCESS for both, and on every WAIT edge for LAT=4.
        do_access(0, 1'b0, 4'h3, 4'h0, 1);
        for (int e = 1; e <= LAT1; e++) do_access(1, 1'b0, 4'h3, 4'h0, e);

        // Full sweep, ascending and descending read-back.
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 16; a++) do_access(k, 1'b1, 4'(a), ~4'(a), 0);
            for (int a = 0; a < 16; a++) do_access(k, 1'b0, 4'(a), 4'h0, 0);
            for (int a = 15; a >= 0; a--) do_access(k, 1'b0, 4'(a), 4'h0, 0);
        end

        // Address boundaries: read-after-write at 15 and 0.
        for (int k = 0; k < 2; k++) begin
            do_access(k, 1'b1, 4'hF, 4'h5, 0);
            do_access(k, 1'b0, 4'hF, 4'h0, 0);
            do_access(k, 1'b1, 4'h0, 4'h9, 0);
            do_access(k, 1'b0, 4'h0, 4'h0, 0);
        end

        // Fault address and its neighbour.
        for (int k = 0; k < 2; k++) begin
            do_access(k, 1'b1, 4'(FAULT_AT), 4'hF, 0);
            do_access(k, 1'b0, 4'(FAULT_AT), 4'h0, 0);
`ifdef MEM_FAULT_INJ_EN
            check("fault_addr_value", 32'(rdata[k]), 32'hE);
`else
            check("fault_addr_value", 32'(rdata[k]), 32'hF);
`endif
            do_access(k, 1'b1, 4'h6, 4'hF, 0);
            do_access(k, 1'b0, 4'h6, 4'h0, 0);
            check("neighbour_value", 32'(rdata[k]), 32'hF);
        end

        // Random mix of reads, writes and aborts.
        for (int i = 0; i < 60; i++) begin
            int  k;
            bit  is_wr;
            int  ab;
            k     = $urandom_range(0, 1);
            is_wr = 1'($urandom);
            ab    = 0;
            if ($urandom_range(0, 4) == 0)
                ab = is_wr ? 1 : $urandom_range(1, (k == 0) ? LAT0 : LAT1);
            do_access(k, is_wr, 4'($urandom), 4'($urandom), ab);
        end

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
